// File: rtl/sar_scan_sequencer.sv
// Scan sequencer for a single 7-bit SAR converter behind an analog input mux.
// Define SAR_SEQ_AVG_EN to convert each channel twice and store the rounded mean.
module sar_scan_sequencer #(
    parameter int NCH     = 4,
    parameter int CW      = $clog2(NCH),
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           cont,
    input  logic [NCH-1:0] ch_mask,
    output logic           soc,
    input  logic           eoc,
    input  logic [6:0]     q,
    output logic [CW-1:0]  mux_sel,
    input  logic [CW-1:0]  rd_addr,
    output logic [6:0]     rd_data,
    output logic [NCH-1:0] valid,
    output logic           busy,
    output logic           scan_done,
    output logic           timeout_err
);

    localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNTW = $clog2(CMAX + 1);

`ifdef SAR_SEQ_AVG_EN
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CONV, S_STORE, S_DONE, S_REARM, S_CONV2} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CONV, S_STORE, S_DONE} state_t;
`endif

    state_t          state, nstate;
    logic [NCH-1:0]  mask;
    logic [CNTW-1:0] cnt;
    logic [6:0]      qcap;
    logic [6:0]      result [NCH];
    logic [CW-1:0]   first_ch, next_ch;
    logic            first_any, next_any;
    logic            settled, tmo, accept, conv_st, advance;
`ifdef SAR_SEQ_AVG_EN
    logic [6:0]      q1;
    logic [7:0]      qsum;
`endif

    // Lowest channel of the incoming mask, and next enabled channel above the current one.
    always_comb begin
        first_any = 1'b0;
        first_ch  = '0;
        next_any  = 1'b0;
        next_ch   = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (ch_mask[i-1]) begin
                first_any = 1'b1;
                first_ch  = CW'(i - 1);
            end
            if (mask[i-1] && ((i - 1) > 32'(mux_sel))) begin
                next_any = 1'b1;
                next_ch  = CW'(i - 1);
            end
        end
    end

`ifdef SAR_SEQ_AVG_EN
    assign conv_st = (state == S_CONV) || (state == S_CONV2);
    assign qsum    = {1'b0, q1} + {1'b0, q} + 8'd1;
`else
    assign conv_st = (state == S_CONV);
`endif
    assign settled = (cnt == CNTW'(SETTLE - 1));
    assign tmo     = conv_st && !eoc && (cnt == CNTW'(TIMEOUT - 1));
    assign accept  = ((state == S_IDLE) && start) || ((state == S_DONE) && cont);
    assign advance = (state == S_STORE) || tmo;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:   if (start) nstate = first_any ? S_SETTLE : S_DONE;
            S_SETTLE: if (settled) nstate = S_CONV;
`ifdef SAR_SEQ_AVG_EN
            S_CONV:   if (eoc) nstate = S_REARM;
                      else if (tmo) nstate = next_any ? S_SETTLE : S_DONE;
            S_REARM:  nstate = S_CONV2;
            S_CONV2:  if (eoc) nstate = S_STORE;
                      else if (tmo) nstate = next_any ? S_SETTLE : S_DONE;
`else
            S_CONV:   if (eoc) nstate = S_STORE;
                      else if (tmo) nstate = next_any ? S_SETTLE : S_DONE;
`endif
            S_STORE:  nstate = next_any ? S_SETTLE : S_DONE;
            S_DONE:   if (cont) nstate = first_any ? S_SETTLE : S_DONE;
                      else nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    always_comb begin
        soc       = !conv_st;
        busy      = (state != S_IDLE);
        scan_done = (state == S_DONE);
    end

    // The converter code is captured at eoc and committed to the register file from STORE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask        <= '0;
            mux_sel     <= '0;
            cnt         <= '0;
            qcap        <= '0;
            valid       <= '0;
            timeout_err <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) result[i] <= '0;
`ifdef SAR_SEQ_AVG_EN
            q1          <= '0;
`endif
        end else begin
            cnt <= (nstate != state) ? '0 : cnt + 1'b1;
            if (accept) begin
                mask        <= ch_mask;
                mux_sel     <= first_ch;
                timeout_err <= 1'b0;
            end
            if (advance && next_any) mux_sel <= next_ch;
            if (tmo) begin
                timeout_err    <= 1'b1;
                valid[mux_sel] <= 1'b0;
            end
            if (state == S_STORE) begin
                result[mux_sel] <= qcap;
                valid[mux_sel]  <= 1'b1;
            end
`ifdef SAR_SEQ_AVG_EN
            if ((state == S_CONV) && eoc)  q1   <= q;
            if ((state == S_CONV2) && eoc) qcap <= qsum[7:1];
`else
            if ((state == S_CONV) && eoc)  qcap <= q;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < NCH) rd_data = result[rd_addr];
    end

endmodule
